pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/hazard_detect.sv | 13 +
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state encodings and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MULTI = 2'b01,
        FLUSH = 2'b10
    } state_e;
    localparam int REG_W = 5;
    localparam int DEF_MULTI_LAT = 4;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between ID sources and the EX load destination.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use
);
    assign load_use = id_valid & ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush FSM for load-use, multi-cycle EX ops and taken MEM branches.
// Defining HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt statistics outputs.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULTI_LAT = DEF_MULTI_LAT,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_multi,
    input  logic             mem_branch,
    input  logic             mem_zero,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             ex_busy,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       state
);
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;
    logic       taken;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    assign taken = mem_branch & mem_zero;
    assign state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Unreachable 2'b11 falls into the RUN branch.
    always_comb begin
        state_d     = RUN;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        ex_busy     = 1'b0;
        case (state_q)
            MULTI: begin
                if (taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = FLUSH;
                end else if (cnt_q != 4'd0) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    ex_busy     = 1'b1;
                    exmem_flush = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                    state_d     = MULTI;
                end else begin
                    ex_busy = 1'b1;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                if (taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    state_d     = FLUSH;
                end else if (ex_multi) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    ex_busy     = 1'b1;
                    exmem_flush = 1'b1;
                    cnt_d       = 4'(MULTI_LAT - 2);
                    state_d     = MULTI;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif
endmodule
